// File: rtl/rpn_evaluator.sv
// Reverse-Polish expression evaluator over a 64-entry token queue with a 16-entry Q8.8 operand stack.
// Multi-cycle DIV (restoring, one quotient bit per cycle) and POW (one multiply per cycle).
module rpn_evaluator #(
  parameter int NUMBER_WIDTH     = 16,
  parameter int TOKEN_WIDTH      = 17,
  parameter int QUEUE_ADDR_WIDTH = 6,
  parameter int STACK_DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUMBER_WIDTH-1:0]     x_value,
  input  logic [QUEUE_ADDR_WIDTH:0]   token_count,
  output logic [QUEUE_ADDR_WIDTH-1:0] token_addr,
  input  logic [TOKEN_WIDTH-1:0]      token,
  output logic                        busy,
  output logic                        done,
  output logic [NUMBER_WIDTH-1:0]     result,
  output logic [3:0]                  error
);
  localparam int W    = NUMBER_WIDTH;
  localparam int SP_W = $clog2(STACK_DEPTH);
  localparam int IX_W = QUEUE_ADDR_WIDTH + 1;
  localparam logic [SP_W:0] D_ONE  = (SP_W+1)'(1);
  localparam logic [SP_W:0] D_TWO  = (SP_W+1)'(2);
  localparam logic [SP_W:0] D_FULL = (SP_W+1)'(STACK_DEPTH);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MUL_LOOP, DIV_LOOP, FINISH} state_t;
  typedef enum logic [2:0] {
    OP_PLUS = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3, OP_POW = 3'd4, OP_VAR = 3'd6
  } opcode_t;

  state_t                   state;
  logic signed [W-1:0]      stack [STACK_DEPTH];
  logic [SP_W:0]            depth;
  logic [IX_W-1:0]          index, count;
  logic signed [W-1:0]      x_reg;
  logic [TOKEN_WIDTH-1:0]   tok;
  logic signed [W-1:0]      acc, base;
  logic [W-9:0]             pow_cnt;
  logic [W+7:0]             quo;
  logic [W-1:0]             rem, divisor;
  logic                     div_neg;
  logic [4:0]               div_cnt;

  function automatic logic signed [W-1:0] mul_q88(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    p = p >>> 8;
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  function automatic logic [W-1:0] apply_sign(input logic [W-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  logic                  is_op, is_push;
  logic [2:0]            opcode;
  logic [SP_W-1:0]       top_idx, sec_idx, st_idx;
  logic signed [W-1:0]   a_val, b_val, push_val, st_data;
  logic                  st_we;
  logic [3:0]            exec_err;
  logic [W:0]            rem_sh, rem_diff;
  logic                  div_ge;
  logic [W-1:0]          rem_nxt;
  logic [W+7:0]          quo_nxt;

  assign token_addr = index[QUEUE_ADDR_WIDTH-1:0];
  assign is_op      = tok[TOKEN_WIDTH-1];
  assign opcode     = tok[2:0];
  assign is_push    = !is_op || (opcode == OP_VAR);
  assign push_val   = is_op ? x_reg : $signed(tok[W-1:0]);
  assign top_idx    = SP_W'(depth - D_ONE);
  assign sec_idx    = SP_W'(depth - D_TWO);
  assign a_val      = stack[sec_idx];
  assign b_val      = stack[top_idx];

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh   = {rem, quo[W+7]};
    rem_diff = rem_sh - {1'b0, divisor};
    div_ge   = (rem_sh >= {1'b0, divisor});
    rem_nxt  = div_ge ? rem_diff[W-1:0] : rem_sh[W-1:0];
    quo_nxt  = {quo[W+6:0], div_ge};
  end

  always_comb begin
    st_we    = 1'b0;
    st_idx   = top_idx;
    st_data  = '0;
    exec_err = 4'b0000;
    case (state)
      EXEC: begin
        if (is_push) begin
          if (depth == D_FULL) exec_err = 4'b0010;
          else begin
            st_we   = 1'b1;
            st_idx  = depth[SP_W-1:0];
            st_data = push_val;
          end
        end else if (opcode == 3'd5 || opcode == 3'd7) begin
          exec_err = 4'b1000;
        end else if (depth < D_TWO) begin
          exec_err = 4'b0001;
        end else begin
          st_idx = sec_idx;
          case (opcode)
            OP_PLUS: begin st_we = 1'b1; st_data = a_val + b_val; end
            OP_SUB:  begin st_we = 1'b1; st_data = a_val - b_val; end
            OP_MUL:  begin st_we = 1'b1; st_data = mul_q88(a_val, b_val); end
            OP_DIV:  if (b_val == '0) exec_err = 4'b0100;
            default: if (b_val[W-1]) exec_err = 4'b1000;
          endcase
        end
      end
      DIV_LOOP: if (div_cnt == 5'd1) begin
        st_we   = 1'b1;
        st_data = apply_sign(quo_nxt[W-1:0], div_neg);
      end
      MUL_LOOP: if (pow_cnt == '0) begin
        st_we   = 1'b1;
        st_data = acc;
      end
      default: ;
    endcase
  end

  // Datapath registers carry no reset; their contents are only consumed under FSM control
  always_ff @(posedge clk) begin
    if (st_we) stack[st_idx] <= st_data;
    if (state == IDLE && start) x_reg <= x_value;
    if (state == FETCH) tok <= token;
    if (state == EXEC) begin
      quo     <= {magnitude(a_val), 8'h00};
      rem     <= '0;
      divisor <= magnitude(b_val);
      div_neg <= a_val[W-1] ^ b_val[W-1];
      acc     <= W'(16'h0100);
      base    <= a_val;
    end
    if (state == DIV_LOOP) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
    if (state == MUL_LOOP) acc <= mul_q88(acc, base);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      error   <= 4'b0000;
      index   <= '0;
      count   <= '0;
      depth   <= '0;
      pow_cnt <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            count <= token_count;
            index <= '0;
            depth <= '0;
            error <= 4'b0000;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (index == count) state <= FINISH;
          else begin
            index <= index + IX_W'(1);
            state <= EXEC;
          end
        end
        EXEC: begin
          if (exec_err != 4'b0000) begin
            error <= exec_err;
            state <= FINISH;
          end else if (is_push) begin
            depth <= depth + D_ONE;
            state <= FETCH;
          end else begin
            depth <= depth - D_ONE;
            case (opcode)
              OP_DIV: begin div_cnt <= 5'(W + 8); state <= DIV_LOOP; end
              OP_POW: begin pow_cnt <= b_val[W-1:8]; state <= MUL_LOOP; end
              default: state <= FETCH;
            endcase
          end
        end
        DIV_LOOP: begin
          div_cnt <= div_cnt - 5'd1;
          if (div_cnt == 5'd1) state <= FETCH;
        end
        MUL_LOOP: begin
          if (pow_cnt == '0) state <= FETCH;
          else pow_cnt <= pow_cnt - 1'b1;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (error == 4'b0000 && depth == D_ONE) result <= b_val;
          else result <= '0;
          if (error == 4'b0000 && depth != D_ONE) error <= 4'b1000;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed bench for rpn_evaluator: arithmetic, multi-cycle ops, error paths, start/reset behaviour.
module tb_rpn_evaluator;
  localparam logic [16:0] T_PLUS = 17'h10000;
  localparam logic [16:0] T_SUB  = 17'h10001;
  localparam logic [16:0] T_MUL  = 17'h10002;
  localparam logic [16:0] T_DIV  = 17'h10003;
  localparam logic [16:0] T_POW  = 17'h10004;
  localparam logic [16:0] T_BAD  = 17'h10005;
  localparam logic [16:0] T_VAR  = 17'h10006;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x_value = '0;
  logic [6:0]  token_count = '0;
  logic [5:0]  token_addr;
  logic [16:0] token;
  logic        busy, done;
  logic [15:0] result;
  logic [3:0]  error;
  logic [16:0] prog [64];

  int n_checks = 0;
  int n_fail = 0;
  int cycles;

  rpn_evaluator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_value(x_value),
    .token_count(token_count), .token_addr(token_addr), .token(token),
    .busy(busy), .done(done), .result(result), .error(error)
  );

  assign token = prog[token_addr];
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic load3(input logic [16:0] t0, input logic [16:0] t1, input logic [16:0] t2);
    prog[0] = t0;
    prog[1] = t1;
    prog[2] = t2;
  endtask

  task automatic kick(input logic [15:0] x, input int n);
    @(negedge clk);
    x_value = x;
    token_count = 7'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_eval(input logic [15:0] x, input int n, output int cyc);
    kick(x, n);
    wait_done(cyc);
  endtask

  task automatic expect_run(input string tag, input logic [15:0] x, input int n,
                            input logic [15:0] exp_res, input logic [3:0] exp_err);
    int c;
    run_eval(x, n, c);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_addr", 32'(token_addr), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    load3(17'h00200, 17'h00300, T_PLUS);
    run_eval(16'h1234, 3, cycles);
    check("add_latency", 32'(cycles), 32'd8);
    check("add_result", 32'(result), 32'h0500);
    check("add_error", 32'(error), 32'h0);
    check("add_busy_at_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1 check("done_one_cycle", 32'(done), 32'd0);

    load3(17'h00200, 17'h00500, T_SUB);
    expect_run("sub", 16'h0, 3, 16'hFD00, 4'b0000);
    load3(17'h07F00, 17'h07F00, T_PLUS);
    expect_run("add_wrap", 16'h0, 3, 16'hFE00, 4'b0000);

    load3(T_VAR, T_VAR, T_MUL);
    expect_run("var_sq", 16'h0180, 3, 16'h0240, 4'b0000);
    load3(17'h0FF00, T_VAR, T_MUL);
    expect_run("neg_mul", 16'h0180, 3, 16'hFE80, 4'b0000);

    load3(17'h00100, 17'h00000, T_DIV);
    expect_run("div0", 16'h0, 3, 16'h0000, 4'b0100);
    repeat (3) @(posedge clk);
    #1 check("err_hold", 32'(error), 32'h4);
    load3(17'h00700, 17'h00200, T_DIV);
    expect_run("div", 16'h0, 3, 16'h0380, 4'b0000);
    load3(17'h0F900, 17'h00200, T_DIV);
    expect_run("div_neg", 16'h0, 3, 16'hFC80, 4'b0000);

    load3(17'h00200, 17'h00300, T_POW);
    expect_run("pow", 16'h0, 3, 16'h0800, 4'b0000);

    // A second start during DIV must be ignored; result holds the previous value until FINISH
    load3(17'h00700, 17'h00200, T_DIV);
    kick(16'h0, 3);
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_result_hold", 32'(result), 32'h0800);
    @(negedge clk);
    token_count = 7'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cycles);
    check("mid_start_result", 32'(result), 32'h0380);
    check("mid_start_error", 32'(error), 32'h0);

    // Asynchronous reset while in DIV_LOOP
    kick(16'h0, 3);
    repeat (10) @(posedge clk);
    #1 check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", 32'(result), 32'h0);
    check("arst_error", 32'(error), 32'h0);
    check("arst_addr", 32'(token_addr), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    expect_run("post_rst_div", 16'h0, 3, 16'h0380, 4'b0000);

    load3(17'h00200, 17'h0FF00, T_POW);
    expect_run("pow_negexp", 16'h0, 3, 16'h0000, 4'b1000);
    load3(17'h00000, 17'h00000, T_POW);
    expect_run("pow_0_0", 16'h0, 3, 16'h0100, 4'b0000);
    load3(T_PLUS, 17'h0, 17'h0);
    expect_run("underflow", 16'h0, 1, 16'h0000, 4'b0001);
    for (int i = 0; i < 17; i++) prog[i] = 17'h00100;
    expect_run("overflow", 16'h0, 17, 16'h0000, 4'b0010);
    expect_run("empty", 16'h0, 0, 16'h0000, 4'b1000);
    load3(17'h00100, 17'h00100, T_BAD);
    expect_run("bad_op", 16'h0, 3, 16'h0000, 4'b1000);
    load3(17'h00100, 17'h00100, T_PLUS);
    expect_run("depth2_left", 16'h0, 2, 16'h0000, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rpn_evaluator.md
RPN_EVALUATOR -- requirements
Module: rpn_evaluator

Interface
REQ-001 Parameters: NUMBER_WIDTH 16 (signed Q8.8 operands/results); TOKEN_WIDTH 17 (operator tag + payload); QUEUE_ADDR_WIDTH 6 (64-entry token queue); STACK_DEPTH 16 (operand stack entries).
REQ-002 Ports, in order: clk in 1 (single clock, all state on rising edge); rst_n in 1 (asynchronous, active-low reset); start in 1 (begin evaluation); x_value in 16 (signed Q8.8 value of variable x, sampled on accepted start); token_count in 7 (number of valid tokens, 0..64, sampled on accepted start); token_addr out 6 (queue read index); token in 17 (queue entry at token_addr, combinational read); busy out 1; done out 1 (one-cycle pulse); result out 16 (signed Q8.8); error out 4 ([0] underflow, [1] overflow, [2] divide-by-zero, [3] invalid).

Function
REQ-003 Token format: bit16=0 means number, bits[15:0] signed Q8.8; bit16=1 means operator, bits[2:0] opcode (0 PLUS, 1 SUB, 2 MUL, 3 DIV, 4 POW, 6 VAR); opcodes 5 and 7 are invalid.
REQ-004 States: IDLE, FETCH, EXEC, MUL_LOOP (POW), DIV_LOOP, FINISH.
REQ-005 IDLE: start=1 latches x_value and token_count, clears index, stack depth and error, sets busy=1, next FETCH; start while busy=1 is ignored.
REQ-006 FETCH: token_addr=index; if index==token_count go to FINISH; else latch token, index+1, go to EXEC.
REQ-007 EXEC: number pushes payload; VAR pushes latched x; binary op pops b (top) then a, pushes a op b; next FETCH unless DIV/POW.
REQ-008 Timing: each number, VAR, PLUS, SUB or MUL token costs exactly 2 cycles (FETCH+EXEC).
REQ-009 PLUS/SUB: 16-bit two's-complement, wrap on overflow, no flag.
REQ-010 MUL: 32-bit signed product, arithmetic shift right 8, keep low 16 bits (wrap).
REQ-011 DIV: b==0 sets error[2]; else restoring division of |a|<<8 by |b|, one quotient bit per cycle in DIV_LOOP (24 cycles), result sign = sign(a) XOR sign(b), magnitude truncated, low 16 bits kept.
REQ-012 POW: exponent = signed integer part b[15:8]; negative sets error[3]; else acc=0x0100 and MUL_LOOP multiplies acc by a (REQ-010 rules), one multiply per cycle, exponent times; 0^0 = 0x0100.
REQ-013 Pop with insufficient depth sets error[0]; push with depth==STACK_DEPTH sets error[1]; invalid opcode sets error[3].
REQ-014 Any error: abort remaining tokens, go to FINISH immediately; at most one error bit set per run (first detected).
REQ-015 FINISH: if no error and depth==1, result=stack top; if no error and depth!=1 (including token_count==0), set error[3]; on any error result=0x0000; done=1 for this one cycle, busy=0, next IDLE.
REQ-016 result and error hold until next accepted start, which clears error and leaves result unchanged until FINISH.
REQ-017 token_addr stays stable while in EXEC/DIV_LOOP/MUL_LOOP; the evaluator never writes the queue.

Reset
REQ-018 rst_n=0 at any time, including mid-evaluation: state IDLE, busy=0, done=0, result=0x0000, error=4'b0000, token_addr=0, stack depth=0, index=0.
REQ-019 After rst_n rises, the first start is accepted on the first rising edge at which it is high.

Verification
REQ-020 x any; tokens [0x00200, 0x00300, 0x10000 PLUS]; start -> done exactly 8 edges after start-sampling edge, result 0x0500, error 0.
REQ-021 x=0x0180; tokens [VAR, VAR, MUL] -> result 0x0240, error 0; then [0x0FF00 (-1.0), VAR, MUL] -> result 0xFE80.
REQ-022 tokens [0x00100, 0x00000, DIV] -> error 4'b0100, result 0x0000; tokens [0x00700, 0x00200, DIV] -> result 0x0380.
REQ-023 tokens [0x00200, 0x00300, POW] -> result 0x0800; [0x00200, 0x0FF00, POW] -> error 4'b1000; [PLUS] -> error 4'b0001; 17 pushes -> error 4'b0010; token_count=0 -> error 4'b1000.
REQ-024 start mid-run ignored (result unaffected); rst_n pulsed low during DIV_LOOP -> all outputs zero asynchronously, next start evaluates normally.
